// File: rtl/hazard_ctrl_seq_pkg.sv
// rtl/hazard_ctrl_seq_pkg.sv - opcodes, FSM encoding and source-register usage helpers
package hazard_ctrl_seq_pkg;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
  localparam logic [6:0] OPCODE_ITYPE = 7'b0010011;
  localparam logic [6:0] OPCODE_ILOAD = 7'b0000011;
  localparam logic [6:0] OPCODE_IJALR = 7'b1100111;
  localparam logic [6:0] OPCODE_STYPE = 7'b0100011;
  localparam logic [6:0] OPCODE_BTYPE = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LSTALL = 2'd1,
    ST_BFLUSH = 2'd2
  } state_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OPCODE_RTYPE, OPCODE_ITYPE, OPCODE_ILOAD,
                      OPCODE_IJALR, OPCODE_STYPE, OPCODE_BTYPE};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OPCODE_RTYPE, OPCODE_STYPE, OPCODE_BTYPE};
  endfunction

endpackage

// File: rtl/hazard_ctrl_seq_md_scoreboard.sv
// rtl/hazard_ctrl_seq_md_scoreboard.sv - pending MUL/DIV destination scoreboard and busy flag
module md_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                md_issue,
  input  logic [REG_W-1:0]    md_rd,
  input  logic                md_done,
  output logic [NUM_REGS-1:0] sb_vec,
  output logic                md_busy
);

  logic [REG_W-1:0]    inflight_rd;
  logic [NUM_REGS-1:0] sb_next;

  // Retire the in-flight op before marking the new one so a same-rd reissue stays set.
  always_comb begin
    sb_next = sb_vec;
    if (md_done) sb_next[inflight_rd] = 1'b0;
    if (md_issue && md_rd != '0) sb_next[md_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_vec      <= '0;
      md_busy     <= 1'b0;
      inflight_rd <= '0;
    end else begin
      sb_vec <= sb_next;
      if (md_issue) begin
        md_busy     <= 1'b1;
        inflight_rd <= md_rd;
      end else if (md_done) begin
        md_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_seq.sv
// rtl/hazard_ctrl_seq.sv - pipeline hazard FSM: load-use, MD scoreboard, branch flush, squash, freeze
module hazard_ctrl_seq
  import hazard_ctrl_seq_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int NUM_REGS          = 32,
  parameter int REG_W             = $clog2(NUM_REGS),
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [6:0]       opcode,
  input  logic             id_is_md,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_load_inst,
  input  logic             md_issue,
  input  logic [REG_W-1:0] md_rd,
  input  logic             md_done,
  input  logic             jump_branch_taken,
  input  logic             invalid_inst,
  input  logic             stall,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             if_id_pipeline_en,
  output logic             if_id_pipeline_flush,
  output logic             id_ex_pipeline_en,
  output logic             id_ex_pipeline_flush,
  output logic             load_stall,
  output logic             md_stall,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t              state, state_next;
  logic [2:0]          cnt, cnt_next;
  logic                flush_evt;
  logic [NUM_REGS-1:0] sb_vec;
  logic                md_busy;
  logic                rs1_used, rs2_used, load_hit, md_hit;

  md_scoreboard #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_issue (md_issue),
    .md_rd    (md_rd),
    .md_done  (md_done),
    .sb_vec   (sb_vec),
    .md_busy  (md_busy)
  );

  assign rs1_used = uses_rs1(opcode) && (id_rs1 != '0);
  assign rs2_used = uses_rs2(opcode) && (id_rs2 != '0);
  assign load_hit = ex_load_inst && (ex_rd != '0) &&
                    ((rs1_used && ex_rd == id_rs1) || (rs2_used && ex_rd == id_rs2));
  assign md_hit   = (rs1_used && sb_vec[id_rs1]) || (rs2_used && sb_vec[id_rs2]) ||
                    (id_is_md && md_busy && !md_done);

  always_comb begin
    state_next           = state;
    cnt_next             = cnt;
    flush_evt            = 1'b0;
    pc_en                = 1'b1;
    if_id_pipeline_en    = 1'b1;
    if_id_pipeline_flush = 1'b0;
    id_ex_pipeline_en    = 1'b1;
    id_ex_pipeline_flush = 1'b0;
    load_stall           = 1'b0;
    md_stall             = 1'b0;

    if ((state == ST_BFLUSH) || jump_branch_taken) begin
      if_id_pipeline_en    = 1'b0;
      if_id_pipeline_flush = 1'b1;
      id_ex_pipeline_flush = 1'b1;
    end

    // A taken redirect wins from any state and restarts the flush window.
    if (jump_branch_taken) begin
      flush_evt = 1'b1;
      cnt_next  = FLUSH_RELOAD;
      state_next = (FLUSH_CYCLES > 1) ? ST_BFLUSH : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_hit || md_hit) begin
            pc_en                = 1'b0;
            if_id_pipeline_en    = 1'b0;
            id_ex_pipeline_flush = 1'b1;
            load_stall           = load_hit;
            md_stall             = !load_hit;
            if (load_hit && LOAD_STALL_CYCLES > 1) begin
              state_next = ST_LSTALL;
              cnt_next   = LOAD_RELOAD;
            end
          end else if (stall) begin
            pc_en             = 1'b0;
            if_id_pipeline_en = 1'b0;
            id_ex_pipeline_en = 1'b0;
          end else if (invalid_inst) begin
            id_ex_pipeline_flush = 1'b1;
            flush_evt            = 1'b1;
          end
        end
        ST_LSTALL: begin
          pc_en                = 1'b0;
          if_id_pipeline_en    = 1'b0;
          id_ex_pipeline_flush = 1'b1;
          load_stall           = 1'b1;
          if (!stall) begin
            cnt_next = cnt - 3'd1;
            if (cnt <= 3'd1) state_next = ST_IDLE;
          end
        end
        ST_BFLUSH: begin
          cnt_next = cnt - 3'd1;
          if (cnt <= 3'd1) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end

    if (!rst_n) begin
      pc_en                = 1'b0;
      if_id_pipeline_en    = 1'b0;
      if_id_pipeline_flush = 1'b1;
      id_ex_pipeline_en    = 1'b0;
      id_ex_pipeline_flush = 1'b1;
      load_stall           = 1'b0;
      md_stall             = 1'b0;
      flush_evt            = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (perf_clr) begin
        stall_count <= '0;
        flush_count <= '0;
      end else begin
        if (!pc_en && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
        if (flush_evt && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// tb/tb_hazard_ctrl_seq.sv - table-driven scoreboard bench for hazard_ctrl_seq
module tb_hazard_ctrl_seq;
  import hazard_ctrl_seq_pkg::*;

  localparam int L = 2, F = 3, NR = 32, RW = 5, CW = 4;
  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, load_stall, md_stall}
  localparam logic [6:0] RUN  = 7'b1101000;
  localparam logic [6:0] BR   = 7'b1011100;
  localparam logic [6:0] LSTL = 7'b0001110;
  localparam logic [6:0] MSTL = 7'b0001101;
  localparam logic [6:0] FRZ  = 7'b0000000;
  localparam logic [6:0] INV  = 7'b1101100;
  localparam logic [6:0] RST  = 7'b0010100;
  localparam logic [6:0] NOP  = 7'h00;

  logic clk = 1'b0, rst_n;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd, md_rd;
  logic [6:0] opcode;
  logic id_is_md, ex_load_inst, md_issue, md_done, jump_branch_taken, invalid_inst, stall, perf_clr;
  logic pc_en, if_id_pipeline_en, if_id_pipeline_flush, id_ex_pipeline_en, id_ex_pipeline_flush;
  logic load_stall, md_stall;
  logic [CW-1:0] stall_count, flush_count;
  logic [6:0] ctl;

  int total = 0, bad = 0;

  typedef struct {
    logic [6:0] exp; logic [6:0] op; logic [4:0] rs1, rs2; logic ld; logic [4:0] exrd;
    logic jbt, stl, inv, ismd, iss; logic [4:0] mdrd; logic done, clr, rstn;
  } row_t;

  logic [6:0] sb_q[$];

  hazard_ctrl_seq #(.LOAD_STALL_CYCLES(L), .FLUSH_CYCLES(F), .NUM_REGS(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .opcode(opcode),
    .id_is_md(id_is_md), .ex_rd(ex_rd), .ex_load_inst(ex_load_inst), .md_issue(md_issue),
    .md_rd(md_rd), .md_done(md_done), .jump_branch_taken(jump_branch_taken),
    .invalid_inst(invalid_inst), .stall(stall), .perf_clr(perf_clr), .pc_en(pc_en),
    .if_id_pipeline_en(if_id_pipeline_en), .if_id_pipeline_flush(if_id_pipeline_flush),
    .id_ex_pipeline_en(id_ex_pipeline_en), .id_ex_pipeline_flush(id_ex_pipeline_flush),
    .load_stall(load_stall), .md_stall(md_stall), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  assign ctl = {pc_en, if_id_pipeline_en, if_id_pipeline_flush, id_ex_pipeline_en,
                id_ex_pipeline_flush, load_stall, md_stall};

  always #5 clk = ~clk;

  function automatic row_t r(input logic [6:0] exp, input logic [6:0] op = NOP,
                             input logic [4:0] rs1 = 0, input logic [4:0] rs2 = 0,
                             input logic ld = 0, input logic [4:0] exrd = 0,
                             input logic jbt = 0, input logic stl = 0, input logic inv = 0,
                             input logic ismd = 0, input logic iss = 0,
                             input logic [4:0] mdrd = 0, input logic done = 0,
                             input logic clr = 0, input logic rstn = 1);
    row_t x;
    x.exp = exp; x.op = op; x.rs1 = rs1; x.rs2 = rs2; x.ld = ld; x.exrd = exrd;
    x.jbt = jbt; x.stl = stl; x.inv = inv; x.ismd = ismd; x.iss = iss; x.mdrd = mdrd;
    x.done = done; x.clr = clr; x.rstn = rstn;
    return x;
  endfunction

  task automatic apply(input row_t x);
    opcode = x.op; id_rs1 = x.rs1; id_rs2 = x.rs2; ex_load_inst = x.ld; ex_rd = x.exrd;
    jump_branch_taken = x.jbt; stall = x.stl; invalid_inst = x.inv; id_is_md = x.ismd;
    md_issue = x.iss; md_rd = x.mdrd; md_done = x.done; perf_clr = x.clr; rst_n = x.rstn;
    sb_q.push_back(x.exp);
  endtask

  task automatic test_reset;
    row_t rows[$];
    logic [6:0] want;
    rows.push_back(r(RST, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(r(RST, OPCODE_RTYPE, 5, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      total++;
      if (ctl !== want) begin bad++; $display("FAIL reset row%0d: got=%b want=%b", i, ctl, want); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_count !== '0 || flush_count !== '0) begin
      bad++; $display("FAIL reset_counters: got=%0d/%0d want=0/0", stall_count, flush_count);
    end
  endtask

  task automatic test_load_use;
    row_t rows[$];
    logic [6:0] want;
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    rows.push_back(r(LSTL, OPCODE_RTYPE, 5, 1, 1, 5));
    rows.push_back(r(LSTL, OPCODE_RTYPE, 5, 1));
    rows.push_back(r(RUN, OPCODE_RTYPE, 5, 1));
    rows.push_back(r(RUN, OPCODE_RTYPE, 0, 0, 1, 0));
    rows.push_back(r(RUN, OPCODE_ITYPE, 1, 5, 1, 5));
    rows.push_back(r(LSTL, OPCODE_STYPE, 1, 5, 1, 5));
    rows.push_back(r(LSTL, OPCODE_STYPE, 1, 5));
    rows.push_back(r(RUN));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      total++;
      if (ctl !== want) begin bad++; $display("FAIL load_use row%0d: got=%b want=%b", i, ctl, want); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_count !== 4'd4 || flush_count !== 4'd0) begin
      bad++; $display("FAIL load_use_counts: got=%0d/%0d want=4/0", stall_count, flush_count);
    end
  endtask

  task automatic test_lstall_freeze;
    row_t rows[$];
    logic [6:0] want;
    rows.push_back(r(LSTL, OPCODE_RTYPE, 6, 9, 1, 6));
    rows.push_back(r(LSTL, NOP, 0, 0, 0, 0, 0, 1));
    rows.push_back(r(LSTL, NOP, 0, 0, 0, 0, 0, 1));
    rows.push_back(r(LSTL));
    rows.push_back(r(RUN));
    rows.push_back(r(FRZ, NOP, 0, 0, 0, 0, 0, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      total++;
      if (ctl !== want) begin bad++; $display("FAIL lstall_freeze row%0d: got=%b want=%b", i, ctl, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_branch;
    row_t rows[$];
    logic [6:0] want;
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    rows.push_back(r(BR, OPCODE_RTYPE, 5, 1, 1, 5, 1));
    rows.push_back(r(BR));
    rows.push_back(r(BR));
    rows.push_back(r(RUN));
    rows.push_back(r(LSTL, OPCODE_RTYPE, 5, 1, 1, 5));
    rows.push_back(r(BR, NOP, 0, 0, 0, 0, 1));
    rows.push_back(r(BR));
    rows.push_back(r(BR));
    rows.push_back(r(RUN));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      total++;
      if (ctl !== want) begin bad++; $display("FAIL load_branch row%0d: got=%b want=%b", i, ctl, want); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_count !== 4'd1 || flush_count !== 4'd2) begin
      bad++; $display("FAIL load_branch_counts: got=%0d/%0d want=1/2", stall_count, flush_count);
    end
  endtask

  task automatic test_md;
    row_t rows[$];
    logic [6:0] want;
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1));
    for (int k = 1; k <= 10; k++)
      rows.push_back(r(MSTL, OPCODE_RTYPE, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, (k == 10)));
    rows.push_back(r(RUN, OPCODE_RTYPE, 7, 0));
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    rows.push_back(r(MSTL, NOP, 0, 0, 0, 0, 0, 0, 0, 1));
    rows.push_back(r(RUN, OPCODE_RTYPE, 9, 10, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      total++;
      if (ctl !== want) begin bad++; $display("FAIL md row%0d: got=%b want=%b", i, ctl, want); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_count !== 4'd11) begin
      bad++; $display("FAIL md_stall_count: got=%0d want=11", stall_count);
    end
  endtask

  task automatic test_md_same_rd;
    row_t rows[$];
    logic [6:0] want;
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3));
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1));
    rows.push_back(r(MSTL, OPCODE_RTYPE, 0, 3));
    rows.push_back(r(MSTL, NOP, 0, 0, 0, 0, 0, 0, 0, 1));
    rows.push_back(r(MSTL, OPCODE_RTYPE, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    rows.push_back(r(RUN, OPCODE_RTYPE, 3, 3));
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      total++;
      if (ctl !== want) begin bad++; $display("FAIL md_same_rd row%0d: got=%b want=%b", i, ctl, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_flush;
    row_t rows[$];
    logic [6:0] want;
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    rows.push_back(r(BR, NOP, 0, 0, 0, 0, 1));
    rows.push_back(r(BR));
    rows.push_back(r(BR, NOP, 0, 0, 0, 0, 1));
    rows.push_back(r(BR));
    rows.push_back(r(BR));
    rows.push_back(r(RUN));
    rows.push_back(r(INV, NOP, 0, 0, 0, 0, 0, 0, 1));
    rows.push_back(r(FRZ, NOP, 0, 0, 0, 0, 0, 1, 1));
    rows.push_back(r(RUN));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      total++;
      if (ctl !== want) begin bad++; $display("FAIL branch_flush row%0d: got=%b want=%b", i, ctl, want); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_count !== 4'd1 || flush_count !== 4'd3) begin
      bad++; $display("FAIL branch_flush_counts: got=%0d/%0d want=1/3", stall_count, flush_count);
    end
  endtask

  task automatic test_saturation;
    row_t rows[$];
    logic [6:0] want;
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 18; k++) rows.push_back(r(FRZ, NOP, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 17; k++) rows.push_back(r(INV, NOP, 0, 0, 0, 0, 0, 0, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      total++;
      if (ctl !== want) begin bad++; $display("FAIL saturation row%0d: got=%b want=%b", i, ctl, want); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_count !== 4'd15 || flush_count !== 4'd15) begin
      bad++; $display("FAIL saturation_counts: got=%0d/%0d want=15/15", stall_count, flush_count);
    end
    apply(r(FRZ, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    want = sb_q.pop_front();
    total++;
    if (ctl !== want) begin bad++; $display("FAIL clr_row: got=%b want=%b", ctl, want); end
    @(posedge clk); #1;
    total++;
    if (stall_count !== '0 || flush_count !== '0) begin
      bad++; $display("FAIL perf_clr_wins: got=%0d/%0d want=0/0", stall_count, flush_count);
    end
  endtask

  task automatic test_reset_mid;
    row_t rows[$];
    logic [6:0] want;
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 5; k++) rows.push_back(r(FRZ, NOP, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 5; k++) rows.push_back(r(INV, NOP, 0, 0, 0, 0, 0, 0, 1));
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9));
    rows.push_back(r(LSTL, OPCODE_RTYPE, 5, 1, 1, 5));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      total++;
      if (ctl !== want) begin bad++; $display("FAIL reset_mid_pre row%0d: got=%b want=%b", i, ctl, want); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_count !== 4'd6 || flush_count !== 4'd5) begin
      bad++; $display("FAIL reset_mid_counts_pre: got=%0d/%0d want=6/5", stall_count, flush_count);
    end
    rows.delete();
    rows.push_back(r(RST, OPCODE_RTYPE, 5, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(r(RUN, OPCODE_RTYPE, 5, 1, 1, 0));
    rows.push_back(r(RUN, OPCODE_RTYPE, 9, 9));
    rows.push_back(r(RUN, NOP, 0, 0, 0, 0, 0, 0, 0, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      total++;
      if (ctl !== want) begin bad++; $display("FAIL reset_mid_post row%0d: got=%b want=%b", i, ctl, want); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_count !== '0 || flush_count !== '0) begin
      bad++; $display("FAIL reset_mid_counts_post: got=%0d/%0d want=0/0", stall_count, flush_count);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    apply(r(RST, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    void'(sb_q.pop_front());
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_lstall_freeze();
    test_load_branch();
    test_md();
    test_md_same_rd();
    test_branch_flush();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
